adc_capture_trig: RTL

- Receive-side counterpart to the DAC900 sine output path: samples a parallel 10-bit ADC on the same 100 MHz clock domain.
- Drives the ADC's inverted sample clock, detects a level/edge trigger and captures a fixed-length record with programmable pre-trigger depth into an on-chip circular buffer.
- Exposes the record through a synchronous read port for the measurement/display logic.
- Used for loopback verification of the DDS/DAC chain.

---
 rtl/adc_capture_trig.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/adc_capture_trig.sv
// rtl/adc_capture_trig.sv - ADC capture with level/edge trigger, pre-trigger depth and circular record buffer
module adc_capture_trig #(
    parameter int DW = 10,
    parameter int AW = 10
) (
    input  logic          DAC900_Clk_r,
    input  logic          rst_n,
    input  logic [DW-1:0] ADC_Data,
    output logic          ADC_Clk,
    output logic          ADC_OE_n,
    input  logic          arm,
    input  logic          trig_edge,
    input  logic [DW-1:0] trig_level,
    input  logic [AW-1:0] pre_len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] trig_addr,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid
);

    localparam logic [AW-1:0] ONE      = AW'(1);
    localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT_TRIG,
        POST,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [DW-1:0] s0;
    logic [DW-1:0] s1;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] cnt;
    logic [AW-1:0] pre_q;
    logic [AW-1:0] post_len;
    logic [AW-1:0] rd_phys;
    logic          wr_en;
    logic          start;
    logic          trig_hit;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    // The ADC latches on the falling edge of our clock, so its data is settled at our rising edge.
    assign ADC_Clk  = ~DAC900_Clk_r;
    assign ADC_OE_n = 1'b0;

    // Samples kept after the trigger sample so that the whole record is exactly N long.
    assign post_len = LAST_IDX - pre_q;

    // Crossing test between the previous sample (s0) and the one being written now (s1).
    assign trig_hit = (state == WAIT_TRIG) &&
                      (trig_edge ? ((s0 <  trig_level) && (s1 >= trig_level))
                                 : ((s0 >= trig_level) && (s1 <  trig_level)));

    // Logical index 0 is the oldest pre-trigger sample; rebase onto the circular buffer.
    assign rd_phys = trig_addr - pre_q + rd_addr;

    // State register.
    always_ff @(posedge DAC900_Clk_r or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; arm is only honoured when no capture is running.
    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        start    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (arm) begin
                    start    = 1'b1;
                    state_nx = (pre_len != '0) ? PRE : WAIT_TRIG;
                end
            end
            PRE: begin
                wr_en = 1'b1;
                if (cnt == pre_q - ONE) begin
                    state_nx = WAIT_TRIG;
                end
            end
            WAIT_TRIG: begin
                wr_en = 1'b1;
                if (trig_hit) begin
                    state_nx = (post_len == '0) ? DONE : POST;
                end
            end
            POST: begin
                wr_en = 1'b1;
                if (cnt == post_len - ONE) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Input pipeline, write pointer, counters and status flags.
    always_ff @(posedge DAC900_Clk_r or negedge rst_n) begin
        if (!rst_n) begin
            s0        <= '0;
            s1        <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            pre_q     <= '0;
            trig_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            s1 <= ADC_Data;
            s0 <= s1;
            if (start) begin
                pre_q <= pre_len;
                cnt   <= '0;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + ONE;
                cnt    <= cnt + ONE;
            end
            if (trig_hit) begin
                trig_addr <= wr_ptr;
                cnt       <= '0;
            end
            busy <= (state_nx == PRE) || (state_nx == WAIT_TRIG) || (state_nx == POST);
            done <= (state_nx == DONE);
        end
    end

    // Record buffer write port; contents survive reset.
    always_ff @(posedge DAC900_Clk_r) begin
        if (wr_en) begin
            mem[wr_ptr] <= s1;
        end
    end

    // Registered read port; data only released once a record is complete.
    always_ff @(posedge DAC900_Clk_r or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en && done;
            if (rd_en && done) begin
                rd_data <= mem[rd_phys];
            end
        end
    end

endmodule
